decade_chain_ctrl: RTL and testbench

//  Controller/sequencer for a cascade of NDIG BCD decade digits (0-9 each) forming an event counter.

---
 rtl/decade_chain_ctrl.sv | 170 +++++++++++++++++
 tb/tb_decade_chain_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decade_chain_ctrl.sv
// Decade-chain event counter controller.
// NDIG cascaded BCD digits (digit 0 least significant) count tick events in RUN.
// Each increment is compared against a BCD target that is latched at start.
// In one-shot mode the chain halts in DONE at the target.
// In auto-reload mode the chain restarts from zero and keeps running.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE 00 | chain cleared, waiting for start
// RUN  01 | counting ticks, matching against latched target
// PAUSE 10| counting suspended, digits and latched config held
// DONE 11 | one-shot target reached, digits hold the target value
module decade_chain_ctrl #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              tick,
  input  logic              reload,
  input  logic [4*NDIG-1:0] target,
  output logic [4*NDIG-1:0] digits,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              cfg_err
);

  localparam int W = 4 * NDIG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic [W-1:0]   target_q, target_d;
  logic           reload_q, reload_d;
  logic           cfg_err_q, cfg_err_d;
  logic           done_q, done_d;
  logic           wrap_q, wrap_d;

  logic [W-1:0]   inc_val;
  logic           inc_carry;
  logic           inc_all9;
  logic           target_bad;
  logic           match;

  // Ripple-carry BCD increment: a digit advances only when every lower digit is 9.
  always_comb begin
    inc_val   = digits_q;
    inc_carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (inc_carry) begin
        if (digits_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
    // Carry out of the top digit means the chain was all 9s and rolled to zero.
    inc_all9 = inc_carry;
  end

  // Flag an incoming target with any non-BCD nibble; latched alongside the target.
  always_comb begin
    target_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (target[4*i +: 4] > 4'd9) begin
        target_bad = 1'b1;
      end
    end
  end

  // Match is judged on the incremented value; a malformed target can never match.
  always_comb begin
    match = !cfg_err_q && (inc_val == target_q);
  end

  // State and data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      target_q  <= '0;
      reload_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      target_q  <= target_d;
      reload_q  <= reload_d;
      cfg_err_q <= cfg_err_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  // Next-state and datapath: command priority is clear > stop > start > tick.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    target_d  = target_q;
    reload_d  = reload_q;
    cfg_err_d = cfg_err_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;

    if (clear) begin
      state_d  = S_IDLE;
      digits_d = '0;
    end else if (stop) begin
      // stop wins over start/tick even where it has no effect of its own.
      if (state_q == S_RUN) begin
        state_d = S_PAUSE;
      end
    end else if (start) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          target_d  = target;
          reload_d  = reload;
          cfg_err_d = target_bad;
          digits_d  = '0;
          state_d   = S_RUN;
        end
        S_PAUSE: begin
          // Resume keeps the configuration captured at the original start.
          state_d = S_RUN;
        end
        default: begin
        end
      endcase
    end else if (tick && (state_q == S_RUN)) begin
      if (match) begin
        done_d = 1'b1;
        if (reload_q) begin
          digits_d = '0;
        end else begin
          digits_d = inc_val;
          state_d  = S_DONE;
        end
      end else begin
        // A rollover that is itself a match reports done instead of wrap.
        digits_d = inc_val;
        wrap_d   = inc_all9;
      end
    end
  end

  // Outputs are taken straight from registers.
  always_comb begin
    digits  = digits_q;
    state   = state_q;
    busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
    done    = done_q;
    wrap    = wrap_q;
    cfg_err = cfg_err_q;
  end

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Directed bench for decade_chain_ctrl with NDIG=2.
module tb_decade_chain_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clear;
  logic       tick;
  logic       reload;
  logic [7:0] target;
  logic [7:0] digits;
  logic [1:0] state;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  decade_chain_ctrl #(.NDIG(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .tick    (tick),
    .reload  (reload),
    .target  (target),
    .digits  (digits),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap),
    .cfg_err (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    tick = 1'b0; reload = 1'b0; target = 8'h00;

    // 1: reset dominates toggling commands
    for (int i = 0; i < 3; i++) begin
      tick  = i[0];
      start = ~i[0];
      step();
      chk("rst_digits", digits, 8'h00);
      chk("rst_state", state, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
    end
    rst = 1'b0; start = 1'b0; tick = 1'b0;
    step();
    chk("idle_state", state, 2'b00);

    // 2: one-shot to 12
    target = 8'h12; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_start_state", state, 2'b01);
    chk("t2_start_digits", digits, 8'h00);
    chk("t2_start_busy", busy, 1'b1);
    tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t2_digits", digits, bcd(k));
      chk("t2_done", done, (k == 12));
      chk("t2_state", state, (k == 12) ? 2'b11 : 2'b01);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_hold_digits", digits, 8'h12);
      chk("t2_hold_done", done, 1'b0);
      chk("t2_hold_busy", busy, 1'b0);
    end
    tick = 1'b0;

    // 3: auto-reload at 03, started from DONE
    target = 8'h03; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_start_digits", digits, 8'h00);
    chk("t3_start_state", state, 2'b01);
    tick = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t3_digits", digits, bcd(k % 3));
      chk("t3_done", done, (k % 3 == 0));
      chk("t3_wrap", wrap, 1'b0);
      chk("t3_state", state, 2'b01);
    end
    tick = 1'b0;

    // 4: malformed target free-runs and wraps
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4_clear_state", state, 2'b00);
    chk("t4_clear_digits", digits, 8'h00);
    target = 8'hA5; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_cfg_err", cfg_err, 1'b1);
    tick = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      step();
      chk("t4_digits", digits, bcd(k % 100));
      chk("t4_wrap", wrap, (k == 100));
      chk("t4_done", done, 1'b0);
      chk("t4_state", state, 2'b01);
    end
    tick = 1'b0;

    // 5: pause/resume and clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    target = 8'h50; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_cfg_err", cfg_err, 1'b0);
    tick = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("t5_run_digits", digits, 8'h07);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_pause_state", state, 2'b10);
    chk("t5_pause_digits", digits, 8'h07);
    chk("t5_pause_busy", busy, 1'b1);
    step();
    step();
    chk("t5_pause_ticks", digits, 8'h07);
    target = 8'h09;
    tick = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_resume_state", state, 2'b01);
    chk("t5_resume_digits", digits, 8'h07);
    tick = 1'b1;
    step();
    chk("t5_resume_tick", digits, 8'h08);
    step();
    chk("t5_no_relatch_digits", digits, 8'h09);
    chk("t5_no_relatch_done", done, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5_clear_digits", digits, 8'h00);
    chk("t5_clear_state", state, 2'b00);
    chk("t5_clear_busy", busy, 1'b0);
    tick = 1'b0;

    // 6: target 00 matches on full rollover
    target = 8'h00; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    tick = 1'b1;
    for (int k = 0; k < 98; k++) step();
    chk("t6_at98", digits, 8'h98);
    step();
    chk("t6_at99", digits, 8'h99);
    chk("t6_at99_done", done, 1'b0);
    step();
    chk("t6_roll_digits", digits, 8'h00);
    chk("t6_roll_done", done, 1'b1);
    chk("t6_roll_wrap", wrap, 1'b0);
    chk("t6_roll_state", state, 2'b11);
    step();
    chk("t6_after_done", done, 1'b0);
    chk("t6_after_digits", digits, 8'h00);
    tick = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
